// File: rtl/spi_slave_rx_if.sv
// SPI pins and parallel register-bus signals of the SPI receive slave.
// The slave modport is the target side; the master modport is the host/SPI-master side.
interface spi_slave_rx_if;
  logic        SCLK;
  logic        CS_n;
  logic        MOSI;
  logic        MISO;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  SCLK, CS_n, MOSI, rd_data,
    output MISO, cmd, addr, wr_data, wr_valid, rd_req, frame_err, busy
  );

  modport master (
    output SCLK, CS_n, MOSI, rd_data,
    input  MISO, cmd, addr, wr_data, wr_valid, rd_req, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-3 slave: oversamples SCLK/CS_n/MOSI on clk, deserialises cmd/addr/data
// frames onto a register bus and returns 32-bit read data on MISO.
module spi_slave_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_WRITE   = 8'h02,
  parameter logic [7:0] CMD_READ    = 8'h03
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_rx_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RREQ, RLOAD, RDATA, DONE
  } state_t;

  state_t state_reg, state_next;

  // Top bit of each SCLK/CS_n chain holds the previous synced value for edge detection.
  logic [SYNC_STAGES:0]   sclk_sync_reg;
  logic [SYNC_STAGES:0]   cs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;

  logic [6:0]  bit_cnt_reg;
  logic [7:0]  cmd_reg;
  logic [23:0] addr_reg;
  logic [31:0] wr_data_reg;
  logic [31:0] tx_shift_reg;
  logic        miso_reg;
  logic        wr_valid_reg, rd_req_reg, frame_err_reg;
  logic        wr_valid_next, rd_req_next, frame_err_next;
  logic        busy_comb, miso_comb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '1;
      // Reset as "selected" so a CS_n held low through reset never looks like a fresh fall.
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-1:0], bus.SCLK};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-1:0], bus.CS_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.MOSI};
    end
  end

  logic cs_low, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_bit;
  assign cs_low    = ~cs_sync_reg[SYNC_STAGES-1];
  assign cs_fall   = ~cs_sync_reg[SYNC_STAGES-1] &  cs_sync_reg[SYNC_STAGES];
  assign cs_rise   =  cs_sync_reg[SYNC_STAGES-1] & ~cs_sync_reg[SYNC_STAGES];
  assign sclk_rise = cs_low &  sclk_sync_reg[SYNC_STAGES-1] & ~sclk_sync_reg[SYNC_STAGES];
  assign sclk_fall = cs_low & ~sclk_sync_reg[SYNC_STAGES-1] &  sclk_sync_reg[SYNC_STAGES];
  assign mosi_bit  = mosi_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg != IDLE && state_reg != DONE && cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  if (cs_fall) state_next = CMD;
        CMD:   if (sclk_rise && bit_cnt_reg == 7'd7) state_next = ADDR;
        ADDR:  if (sclk_rise && bit_cnt_reg == 7'd31) begin
                 if (cmd_reg == CMD_WRITE)     state_next = WDATA;
                 else if (cmd_reg == CMD_READ) state_next = RREQ;
                 else                          state_next = DONE;
               end
        WDATA: if (sclk_rise && bit_cnt_reg == 7'd63) state_next = DONE;
        RREQ:  state_next = RLOAD;
        RLOAD: state_next = RDATA;
        RDATA: if (sclk_rise && bit_cnt_reg == 7'd63) state_next = DONE;
        DONE:  if (cs_rise) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pulses are decoded from transitions so the three of them can never overlap.
  always_comb begin
    wr_valid_next  = (state_reg == WDATA) && (state_next == DONE);
    rd_req_next    = (state_reg == ADDR) && (state_next == RREQ);
    frame_err_next = ((state_reg != IDLE) && (state_reg != DONE) && (state_next == IDLE))
                   || ((state_reg == ADDR) && (state_next == DONE));
    busy_comb      = (state_reg != IDLE);
    miso_comb      = (state_reg == RDATA) ? miso_reg : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg   <= '0;
      cmd_reg       <= '0;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
      tx_shift_reg  <= '0;
      miso_reg      <= 1'b0;
      wr_valid_reg  <= 1'b0;
      rd_req_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      wr_valid_reg  <= wr_valid_next;
      rd_req_reg    <= rd_req_next;
      frame_err_reg <= frame_err_next;

      if (state_reg == IDLE && cs_fall) begin
        bit_cnt_reg <= '0;
      end else if (sclk_rise && (state_reg inside {CMD, ADDR, WDATA, RDATA})) begin
        bit_cnt_reg <= bit_cnt_reg + 7'd1;
        case (state_reg)
          CMD:     cmd_reg     <= {cmd_reg[6:0], mosi_bit};
          ADDR:    addr_reg    <= {addr_reg[22:0], mosi_bit};
          WDATA:   wr_data_reg <= {wr_data_reg[30:0], mosi_bit};
          default: ;
        endcase
      end

      if (state_reg == RLOAD) begin
        tx_shift_reg <= bus.rd_data;
        miso_reg     <= 1'b0;
      end else if (state_reg == RDATA && sclk_fall) begin
        miso_reg     <= tx_shift_reg[31];
        tx_shift_reg <= {tx_shift_reg[30:0], 1'b0};
      end
    end
  end

  assign bus.MISO      = miso_comb;
  assign bus.cmd       = cmd_reg;
  assign bus.addr      = addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.wr_valid  = wr_valid_reg;
  assign bus.rd_req    = rd_req_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_comb;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed and random SPI frames are compared
// against a frame-level reference model of the expected register-bus results.
module tb_spi_slave_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_rx_if bus_if ();

  logic [31:0] rd_val   = 32'h0;
  logic [31:0] rd_drive = 32'h0;
  assign bus_if.rd_data = rd_drive;

  spi_slave_rx #(.SYNC_STAGES(2), .CMD_WRITE(8'h02), .CMD_READ(8'h03)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_frame = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses, flags overlaps or pulses longer than one clk.
  int wv_cnt = 0, rq_cnt = 0, fe_cnt = 0, shape_cnt = 0;
  logic wv_q = 1'b0, rq_q = 1'b0, fe_q = 1'b0;
  logic [63:0] snap = 64'h0;
  always @(negedge clk) begin
    wv_cnt <= wv_cnt + int'(bus_if.wr_valid);
    rq_cnt <= rq_cnt + int'(bus_if.rd_req);
    fe_cnt <= fe_cnt + int'(bus_if.frame_err);
    if ((bus_if.wr_valid && wv_q) || (bus_if.rd_req && rq_q) || (bus_if.frame_err && fe_q) ||
        ($countones({bus_if.wr_valid, bus_if.rd_req, bus_if.frame_err}) > 1))
      shape_cnt <= shape_cnt + 1;
    if (bus_if.wr_valid) snap <= {bus_if.cmd, bus_if.addr, bus_if.wr_data};
    wv_q <= bus_if.wr_valid;
    rq_q <= bus_if.rd_req;
    fe_q <= bus_if.frame_err;
  end

  // Register-bus responder: read data valid only in the clk after rd_req.
  always @(negedge clk) begin
    if (bus_if.rd_req) begin
      @(posedge clk);
      #1 rd_drive <= rd_val;
      @(posedge clk);
      #1 rd_drive <= ~rd_val;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SCLK at clk/8, MOSI set on the falling edge, MISO sampled just before each rising edge.
  task automatic send_bits(input logic [63:0] bits, input int nbits, input int extra,
                           output logic [31:0] mword, output logic mor);
    mword = 32'h0;
    mor   = 1'b0;
    for (int i = 0; i < nbits + extra; i++) begin
      bus_if.SCLK = 1'b0;
      bus_if.MOSI = (i < nbits && i < 64) ? bits[6'(63 - i)] : 1'($urandom);
      tick(4);
      if (i >= 32 && i < 64) mword[5'(63 - i)] = bus_if.MISO;
      mor |= bus_if.MISO;
      bus_if.SCLK = 1'b1;
      tick(4);
    end
  endtask

  // Result of shifting the first k bits (MSB first) of a w-bit field into a w-bit register.
  function automatic logic [63:0] shift_in(input logic [63:0] old, input logic [63:0] nw,
                                           input int k, input int w);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    int kk = (k > w) ? w : k;
    if (kk <= 0) return old;
    return ((old << kk) | (nw >> (w - kk))) & mask;
  endfunction

  logic [7:0]  m_cmd   = 8'h0;
  logic [23:0] m_addr  = 24'h0;
  logic [31:0] m_wdata = 32'h0;

  task automatic run_frame(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                           input logic [31:0] rv, input int nbits, input int extra, input int gap);
    int wv0, rq0, fe0, sh0;
    logic [31:0] mword;
    logic mor;
    bit is_w, is_r, exp_wv, exp_rq, exp_fe;
    wv0 = wv_cnt; rq0 = rq_cnt; fe0 = fe_cnt; sh0 = shape_cnt;
    rd_val = rv;
    bus_if.CS_n = 1'b0;
    tick(4);
    send_bits({c, a, d}, nbits, extra, mword, mor);
    bus_if.CS_n = 1'b1;
    tick(4);
    n_frame++;
    $display("frame %0d: cmd=%02h addr=%06h data=%08h rd=%08h bits=%0d extra=%0d",
             n_frame, c, a, d, rv, nbits, extra);

    is_w   = (c == 8'h02);
    is_r   = (c == 8'h03);
    exp_wv = is_w && nbits >= 64;
    exp_rq = is_r && nbits >= 32;
    exp_fe = !exp_wv && !(is_r && nbits >= 64);
    m_cmd  = 8'(shift_in(64'(m_cmd), 64'(c), nbits, 8));
    m_addr = 24'(shift_in(64'(m_addr), 64'(a), nbits - 8, 24));
    if (is_w) m_wdata = 32'(shift_in(64'(m_wdata), 64'(d), nbits - 32, 32));

    check_eq("busy_after_cs", 64'(bus_if.busy), 64'h0);
    check_eq("wr_valid_cnt", 64'(wv_cnt - wv0), 64'(exp_wv));
    check_eq("rd_req_cnt", 64'(rq_cnt - rq0), 64'(exp_rq));
    check_eq("frame_err_cnt", 64'(fe_cnt - fe0), 64'(exp_fe));
    check_eq("pulse_shape", 64'(shape_cnt - sh0), 64'h0);
    check_eq("cmd", 64'(bus_if.cmd), 64'(m_cmd));
    check_eq("addr", 64'(bus_if.addr), 64'(m_addr));
    check_eq("wr_data", 64'(bus_if.wr_data), 64'(m_wdata));
    if (exp_wv) check_eq("wr_valid_snapshot", snap, {c, a, d});
    if (is_r && nbits >= 64) check_eq("miso_word", 64'(mword), 64'(rv));
    else if (!is_r) check_eq("miso_idle", 64'(mor), 64'h0);
    if (gap > 4) tick(gap - 4);
  endtask

  initial begin
    int wv0, rq0, fe0;
    logic [31:0] mw;
    logic mo;
    logic [7:0] c;
    int nb, ex;

    bus_if.SCLK = 1'b1;
    bus_if.CS_n = 1'b1;
    bus_if.MOSI = 1'b0;
    tick(3);
    check_eq("reset_regs", {bus_if.cmd, bus_if.addr, bus_if.wr_data}, 64'h0);
    check_eq("reset_ctl", 64'({bus_if.MISO, bus_if.busy, bus_if.wr_valid, bus_if.rd_req,
                               bus_if.frame_err}), 64'h0);
    rst = 1'b0;
    tick(4);

    run_frame(8'h02, 24'h123456, 32'hDEADBEEF, 32'h0, 64, 0, 8);   // write
    run_frame(8'h03, 24'h00ABCD, 32'h5A5A5A5A, 32'hCAFEF00D, 64, 0, 8); // read
    run_frame(8'h02, 24'h654321, 32'h13579BDF, 32'h0, 40, 0, 8);   // abort mid-data
    run_frame(8'h9F, 24'h777777, 32'h0, 32'h0, 32, 32, 8);         // bad opcode
    run_frame(8'h02, 24'h000001, 32'h11111111, 32'h0, 64, 0, 4);   // back-to-back
    run_frame(8'h02, 24'h000002, 32'h22222222, 32'h0, 64, 0, 8);

    // Reset in the address phase, then CS_n left low: no frame without a fresh fall.
    wv0 = wv_cnt; rq0 = rq_cnt; fe0 = fe_cnt;
    bus_if.CS_n = 1'b0;
    tick(4);
    send_bits(64'h02ABCDEF_01234567, 16, 0, mw, mo);
    rst = 1'b1;
    #1;
    check_eq("midframe_rst_regs", {bus_if.cmd, bus_if.addr, bus_if.wr_data}, 64'h0);
    check_eq("midframe_rst_ctl", 64'({bus_if.MISO, bus_if.busy, bus_if.wr_valid, bus_if.rd_req,
                                      bus_if.frame_err}), 64'h0);
    m_cmd = 8'h0; m_addr = 24'h0; m_wdata = 32'h0;
    tick(2);
    rst = 1'b0;
    send_bits(64'hFFFFFFFF_FFFFFFFF, 8, 0, mw, mo);
    check_eq("no_restart_busy", 64'(bus_if.busy), 64'h0);
    bus_if.CS_n = 1'b1;
    tick(6);
    check_eq("no_restart_pulses", 64'((wv_cnt - wv0) + (rq_cnt - rq0) + (fe_cnt - fe0)), 64'h0);
    check_eq("no_restart_cmd", 64'(bus_if.cmd), 64'h0);
    run_frame(8'h02, 24'hA5A5A5, 32'h0BADF00D, 32'h0, 64, 0, 8);

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0:       c = 8'h02;
        1:       c = 8'h03;
        default: c = 8'($urandom);
      endcase
      nb = ($urandom_range(0, 1) == 1) ? 64 : int'($urandom_range(1, 63));
      ex = (nb == 64 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_frame(c, 24'($urandom), $urandom, $urandom, nb, ex, int'($urandom_range(4, 10)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
